// File: rtl/bam_pkg.sv
// Shared definitions for the Booth array multiplier slice.
//   WIDTH_DEFAULT : default operand width
//   booth_op_e    : decoded action for one radix-2 Booth bit pair
//   booth_decode  : maps pair {b[i], b[i-1]} to an action
package bam_pkg;

  localparam int WIDTH_DEFAULT = 32;

  // Raw pair encodings as scanned from the multiplier.
  localparam logic [1:0] PAIR_NOP0 = 2'b00;
  localparam logic [1:0] PAIR_ADD  = 2'b01;
  localparam logic [1:0] PAIR_SUB  = 2'b10;
  localparam logic [1:0] PAIR_NOP1 = 2'b11;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_e;

  function automatic booth_op_e booth_decode(input logic [1:0] pair);
    booth_op_e op;
    op = OP_NOP;
    case (pair)
      PAIR_ADD:  op = OP_ADD;
      PAIR_SUB:  op = OP_SUB;
      default:   op = OP_NOP;  // 00 and 11: inside a run, nothing to add
    endcase
    return op;
  endfunction

endpackage

// File: rtl/bam_if.sv
// Operand / control / product bundle for bam_integrated.
//   Multiplicand, Multiplier : signed operands (WIDTH)
//   enableA/B/Out            : level-sampled load enables
//   resetA/B/Out             : synchronous clears (win over enables)
//   Product                  : registered signed product (2*WIDTH)
// master drives operands and controls; slave is the multiplier.
interface bam_if #(
  parameter int WIDTH = bam_pkg::WIDTH_DEFAULT
);
  logic [WIDTH-1:0]   Multiplicand;
  logic [WIDTH-1:0]   Multiplier;
  logic               enableA;
  logic               enableB;
  logic               enableOut;
  logic               resetA;
  logic               resetB;
  logic               resetOut;
  logic [2*WIDTH-1:0] Product;

  modport master (
    output Multiplicand, Multiplier, enableA, enableB, enableOut,
           resetA, resetB, resetOut,
    input  Product
  );

  modport slave (
    input  Multiplicand, Multiplier, enableA, enableB, enableOut,
           resetA, resetB, resetOut,
    output Product
  );
endinterface

// File: rtl/booth_core.sv
// Combinational radix-2 Booth multiplier, fully unrolled over WIDTH steps.
//   a : signed multiplicand (WIDTH)
//   b : signed multiplier   (WIDTH)
//   p : signed product      (2*WIDTH), wraps modulo 2^(2*WIDTH)
// Step i looks at {b[i], b[i-1]} (b[-1]=0) and adds, subtracts or skips
// the sign-extended multiplicand shifted left by i.
module booth_core
  import bam_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  logic [2*WIDTH-1:0] a_ext;
  logic [WIDTH:0]     b_ext;   // b with the implicit b[-1]=0 appended
  logic [2*WIDTH-1:0] acc [WIDTH+1];

  assign a_ext  = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_ext  = {b, 1'b0};
  assign acc[0] = '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_step
    booth_op_e          op;
    logic [2*WIDTH-1:0] pp;

    assign op = booth_decode(b_ext[i+1:i]);
    assign pp = a_ext << i;

    always_comb begin
      acc[i+1] = acc[i];
      case (op)
        OP_ADD:  acc[i+1] = acc[i] + pp;
        OP_SUB:  acc[i+1] = acc[i] - pp;
        default: acc[i+1] = acc[i];
      endcase
    end
  end

  assign p = acc[WIDTH];

endmodule

// File: rtl/bam_integrated.sv
// Registered Booth multiplier: operand registers A/B feed a combinational
// Booth core whose result is captured by the product register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset of all three registers
//   bus   : bam_if.slave (operands, enables, sync clears, Product)
// Product lags operand load by one edge; if operands and product load on
// the same edge, the product reflects the previous operands.
module bam_integrated
  import bam_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  bam_if.slave bus
);

  logic [WIDTH-1:0]   rega;
  logic [WIDTH-1:0]   regb;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] core_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           rega <= '0;
    else if (bus.resetA)  rega <= '0;
    else if (bus.enableA) rega <= bus.Multiplicand;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           regb <= '0;
    else if (bus.resetB)  regb <= '0;
    else if (bus.enableB) regb <= bus.Multiplier;
  end

  booth_core #(.WIDTH(WIDTH)) u_core (
    .a (rega),
    .b (regb),
    .p (core_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             prod <= '0;
    else if (bus.resetOut)  prod <= '0;
    else if (bus.enableOut) prod <= core_p;
  end

  assign bus.Product = prod;

endmodule

// File: tb/tb_bam_integrated.sv
// Directed bench for bam_integrated: hand-computed products, control and
// reset behaviour.
module tb_bam_integrated;
  import bam_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  bam_if #(.WIDTH(W)) bus ();

  bam_integrated #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2*W-1:0] act,
                     input logic [2*W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic idle();
    bus.enableA   = 1'b0;
    bus.enableB   = 1'b0;
    bus.enableOut = 1'b0;
    bus.resetA    = 1'b0;
    bus.resetB    = 1'b0;
    bus.resetOut  = 1'b0;
  endtask

  // Load operands on one edge, capture product on the next, then check.
  task automatic mul(input string tag, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [2*W-1:0] exp);
    @(negedge clk);
    idle();
    bus.Multiplicand = a;
    bus.Multiplier   = b;
    bus.enableA      = 1'b1;
    bus.enableB      = 1'b1;
    @(negedge clk);
    idle();
    bus.enableOut    = 1'b1;
    @(negedge clk);
    idle();
    chk(tag, bus.Product, exp);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.Multiplicand = '0;
    bus.Multiplier   = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_product", bus.Product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency: operands loaded, product not yet captured.
    @(negedge clk);
    bus.Multiplicand = 32'd5;
    bus.Multiplier   = 32'd6;
    bus.enableA = 1'b1;
    bus.enableB = 1'b1;
    @(negedge clk);
    idle();
    chk("latency_hold0", bus.Product, 64'd0);
    bus.enableOut = 1'b1;
    @(negedge clk);
    idle();
    chk("mul_5x6", bus.Product, 64'd30);

    mul("mul_m4xm7",   -32'sd4,  -32'sd7, 64'd28);
    mul("mul_10xm4",    32'd10,  -32'sd4, 64'hFFFFFFFF_FFFFFFD8);
    mul("mul_m50x5",   -32'sd50,  32'd5,  64'hFFFFFFFF_FFFFFF06);
    mul("mul_1234x0",   32'd1234, 32'd0,  64'd0);
    mul("mul_99x1",     32'd99,   32'd1,  64'd99);
    mul("mul_32x23",    32'd32,   32'd23, 64'd736);
    mul("mul_min_min",  32'h80000000, 32'h80000000, 64'h40000000_00000000);
    mul("mul_max_min",  32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000);
    mul("mul_m1xm1",    32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1);

    // Hold: Product stays at 99*1... current is 1 (-1*-1); load new operands.
    mul("mul_7x3", 32'd7, 32'd3, 64'd21);
    @(negedge clk);
    bus.Multiplicand = 32'd100;
    bus.Multiplier   = 32'd100;
    bus.enableA = 1'b1;
    bus.enableB = 1'b1;
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("hold_no_enout", bus.Product, 64'd21);

    // Same-edge operand + product load captures the old operands (100*100).
    bus.Multiplicand = 32'd2;
    bus.Multiplier   = 32'd3;
    bus.enableA   = 1'b1;
    bus.enableB   = 1'b1;
    bus.enableOut = 1'b1;
    @(negedge clk);
    idle();
    chk("same_edge_old", bus.Product, 64'd10000);
    bus.enableOut = 1'b1;
    @(negedge clk);
    idle();
    chk("same_edge_new", bus.Product, 64'd6);

    // resetOut wins over enableOut.
    bus.resetOut  = 1'b1;
    bus.enableOut = 1'b1;
    @(negedge clk);
    idle();
    chk("resetout_wins", bus.Product, 64'd0);

    // resetA wins over enableA: regA cleared, product becomes 0.
    bus.enableOut = 1'b1;
    @(negedge clk);
    idle();
    chk("reload_2x3", bus.Product, 64'd6);
    bus.Multiplicand = 32'd9;
    bus.enableA = 1'b1;
    bus.resetA  = 1'b1;
    @(negedge clk);
    idle();
    bus.enableOut = 1'b1;
    @(negedge clk);
    idle();
    chk("reseta_wins", bus.Product, 64'd0);

    // resetB clears regB only.
    bus.Multiplicand = 32'd9;
    bus.enableA = 1'b1;
    @(negedge clk);
    idle();
    bus.enableOut = 1'b1;
    @(negedge clk);
    idle();
    chk("a9_b3", bus.Product, 64'd27);
    bus.resetB = 1'b1;
    @(negedge clk);
    idle();
    bus.enableOut = 1'b1;
    @(negedge clk);
    idle();
    chk("resetb_clears", bus.Product, 64'd0);

    // Async reset mid-cycle clears everything immediately.
    mul("mul_11x13", 32'd11, 32'd13, 64'd143);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_prod", bus.Product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.enableOut = 1'b1;
    @(negedge clk);
    idle();
    chk("async_rst_regs", bus.Product, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
